// File: rtl/awgn_urng_taus.sv
// Dual taus88 uniform source: two independent three-component Tausworthe
// generators produce one 64-bit sample per enabled clock for the LZD and sin/cos paths.
module awgn_urng_taus #(
    parameter logic [31:0] SEED_A1 = 32'h1234_5678,
    parameter logic [31:0] SEED_A2 = 32'h9ABC_DEF0,
    parameter logic [31:0] SEED_A3 = 32'h0F1E_2D3C,
    parameter logic [31:0] SEED_B1 = 32'h4B5A_6978,
    parameter logic [31:0] SEED_B2 = 32'h8796_A5B4,
    parameter logic [31:0] SEED_B3 = 32'hC3D2_E1F0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         seed_ld_i,
    input  logic [191:0] seed_in_i,
    input  logic         en_i,
    output logic [47:0]  u0_o,
    output logic [15:0]  u1_o,
    output logic         valid_o
);

    function automatic logic [31:0] taus_s1(input logic [31:0] s);
        return ((s & 32'hFFFF_FFFE) << 12) ^ (((s << 13) ^ s) >> 19);
    endfunction

    function automatic logic [31:0] taus_s2(input logic [31:0] s);
        return ((s & 32'hFFFF_FFF8) << 4) ^ (((s << 2) ^ s) >> 25);
    endfunction

    function automatic logic [31:0] taus_s3(input logic [31:0] s);
        return ((s & 32'hFFFF_FFF0) << 17) ^ (((s << 3) ^ s) >> 11);
    endfunction

    logic [31:0] a1_q, a2_q, a3_q, b1_q, b2_q, b3_q;
    logic [31:0] a1_d, a2_d, a3_d, b1_d, b2_d, b3_d;
    logic [31:0] a1_n, a2_n, a3_n, b1_n, b2_n, b3_n;
    logic [31:0] a_out, b_out;
    logic [47:0] u0_q, u0_d;
    logic [15:0] u1_q, u1_d;
    logic        valid_q, valid_d;

    assign a1_n  = taus_s1(a1_q);
    assign a2_n  = taus_s2(a2_q);
    assign a3_n  = taus_s3(a3_q);
    assign b1_n  = taus_s1(b1_q);
    assign b2_n  = taus_s2(b2_q);
    assign b3_n  = taus_s3(b3_q);
    assign a_out = a1_n ^ a2_n ^ a3_n;
    assign b_out = b1_n ^ b2_n ^ b3_n;

    always_comb begin
        a1_d    = a1_q;
        a2_d    = a2_q;
        a3_d    = a3_q;
        b1_d    = b1_q;
        b2_d    = b2_q;
        b3_d    = b3_q;
        u0_d    = u0_q;
        u1_d    = u1_q;
        valid_d = 1'b0;
        if (seed_ld_i) begin
            // A word stuck below its shift mask would lock its component at zero.
            a1_d = (|seed_in_i[31:1])    ? seed_in_i[31:0]    : SEED_A1;
            a2_d = (|seed_in_i[63:35])   ? seed_in_i[63:32]   : SEED_A2;
            a3_d = (|seed_in_i[95:68])   ? seed_in_i[95:64]   : SEED_A3;
            b1_d = (|seed_in_i[127:97])  ? seed_in_i[127:96]  : SEED_B1;
            b2_d = (|seed_in_i[159:131]) ? seed_in_i[159:128] : SEED_B2;
            b3_d = (|seed_in_i[191:164]) ? seed_in_i[191:160] : SEED_B3;
        end else if (en_i) begin
            a1_d    = a1_n;
            a2_d    = a2_n;
            a3_d    = a3_n;
            b1_d    = b1_n;
            b2_d    = b2_n;
            b3_d    = b3_n;
            u0_d    = {a_out, b_out[31:16]};
            u1_d    = b_out[15:0];
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_q    <= SEED_A1;
            a2_q    <= SEED_A2;
            a3_q    <= SEED_A3;
            b1_q    <= SEED_B1;
            b2_q    <= SEED_B2;
            b3_q    <= SEED_B3;
            u0_q    <= '0;
            u1_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            a3_q    <= a3_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            b3_q    <= b3_d;
            u0_q    <= u0_d;
            u1_q    <= u1_d;
            valid_q <= valid_d;
        end
    end

    assign u0_o    = u0_q;
    assign u1_o    = u1_q;
    assign valid_o = valid_q;

endmodule
